uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Byte buffer between the UART receive path and the UART transmit path.
- Accepts one-cycle byte strobes from the receiver and stores them in a circular FIFO.
- Hands bytes to the transmitter one at a time with a start/busy handshake, so back-to-back received bytes are not lost while the transmitter is still shifting.
- Also reports fill level and a sticky overflow flag.

Parameters:
- DATA_W, 8, byte width.
- ADDR_W, 4, pointer width; DEPTH = 2**ADDR_W (16 entries).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  synchronous reset, active-high. The name follows codebase practice; 1 = reset.
- wr_en  in  1  one-cycle strobe from the receiver: wr_data is valid.
- wr_data  in  DATA_W  received byte.
- tx_busy  in  1  transmitter shifting a frame; high from at most 1 cycle after tx_start until the stop bit ends.
- clr_ovf  in  1  clears overflow.
- tx_start  out  1  one-cycle pulse: transmitter must load tx_data.
- tx_data  out  DATA_W  byte for transmitter; registered.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  ADDR_W+1  stored entries, range 0..DEPTH.
- overflow  out  1  sticky: a write was dropped.

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - wr_ptr, rd_ptr, count, tx_data, tx_start, overflow all go to 0; empty=1, full=0; FSM goes to IDLE.
  - Storage contents are don't-care.
  - Reset mid-frame: any byte already popped is discarded; FIFO contents are lost.
- Write:
  - On wr_en with !full: mem[wr_ptr] <= wr_data and wr_ptr increments. Pointers wrap modulo DEPTH (natural ADDR_W rollover).
  - On wr_en with full: byte dropped, overflow <= 1, no pointer or count change.
  - Exception: if a pop occurs in the same cycle, the write is accepted and no overflow is flagged.
- Pop: occurs only in state ISSUE. rd_ptr increments (wraps).
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - full and empty are derived from registered count; no pointer-compare ambiguity.
- Overflow flag:
  - clr_ovf clears it.
  - If clr_ovf and a dropped write occur in the same cycle, set wins (overflow=1).
- FSM (registered states):
  - IDLE: if !empty && !tx_busy -> ISSUE; else stay.
  - ISSUE, one cycle:
    - tx_start=1.
    - tx_data holds mem[rd_ptr], loaded on entry (i.e. at the IDLE->ISSUE edge), so it is valid in the same cycle as tx_start.
    - Pop at end of cycle; go to WAIT_BUSY.
  - WAIT_BUSY: stay until tx_busy=1, then -> WAIT_DONE.
  - WAIT_DONE: stay until tx_busy=0, then -> IDLE.
- tx_start is 0 in every state except ISSUE.
- tx_data holds its value until the next ISSUE.
- Latency:
  - wr_en in cycle 0 into an empty FIFO with transmitter idle: count=1 in cycle 1, ISSUE (tx_start=1) in cycle 2.
  - Minimum spacing between consecutive tx_start pulses is 4 cycles (ISSUE, WAIT_BUSY, WAIT_DONE, IDLE). In practice it is bounded by the frame time.
- Writes are accepted in every FSM state, including during ISSUE.
- Ordering is strictly first in, first out. No byte is duplicated or reordered.

Test Plan:
- Single byte: after reset, wr_en with 0xA5 at cycle 0; model the transmitter with busy for 10 cycles. Expect count=1 at cycle 1, tx_start at cycle 2 with tx_data=0xA5, count=0 at cycle 3, exactly one tx_start, and empty=1 at the end.
- Burst: write 0x01..0x05 on consecutive cycles while the transmitter model is busy 100 cycles per frame. Expect count to peak at 4 or 5, and 5 tx_start pulses in order 0x01..0x05, each issued only after tx_busy falls.
- Full/overflow: hold tx_busy=1 and write 17 bytes 0x10..0x20. Expect full=1 after 16 writes, count=16, overflow=1, and 0x20 dropped. Release busy and expect 0x10..0x1F drained.
- Wrap and simultaneous push/pop: pre-fill 16 bytes; in the ISSUE cycle write 0x77. Expect count to stay 16, overflow=0, and 0x77 drained last after the wrapped pointers.
- Overflow clear: with overflow=1, pulse clr_ovf and expect 0 next cycle. Pulse clr_ovf together with a dropped write and expect overflow to stay 1.
- Reset mid-operation: load 3 bytes and assert rst_n=1 for one cycle during WAIT_DONE. Expect count=0, empty=1, tx_start=0, tx_data=0, FSM in IDLE, and no further tx_start until a new write.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Byte path between the UART receiver, the TX buffer and the UART transmitter.
// master = receiver/transmitter side, slave = the buffer itself.
`timescale 1ns/1ps
interface uart_tx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              tx_busy;
    logic              clr_ovf;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;

    modport master (
        output wr_en, wr_data, tx_busy, clr_ovf,
        input  tx_start, tx_data, full, empty, count, overflow
    );

    modport slave (
        input  wr_en, wr_data, tx_busy, clr_ovf,
        output tx_start, tx_data, full, empty, count, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding the UART transmitter one byte per frame through a
// start/busy handshake; reports fill level and a sticky overflow flag.
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_fifo_if.slave  bus
);
    // state     | meaning
    // IDLE      | waiting for a stored byte and an idle transmitter
    // ISSUE     | tx_start high, tx_data valid, byte popped at end of cycle
    // WAIT_BUSY | waiting for the transmitter to report busy
    // WAIT_DONE | waiting for the transmitter to finish the frame
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    localparam int DEPTH = 2**ADDR_W;

    state_t            state, state_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] tx_data;
    logic              overflow;
    logic              push, pop, drop;

    assign pop  = (state == ISSUE);
    // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
    assign push = bus.wr_en && (!bus.full || pop);
    assign drop = bus.wr_en && bus.full && !pop;

    assign bus.full     = (count == (ADDR_W+1)'(DEPTH));
    assign bus.empty    = (count == '0);
    assign bus.count    = count;
    assign bus.tx_start = (state == ISSUE);
    assign bus.tx_data  = tx_data;
    assign bus.overflow = overflow;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!bus.empty && !bus.tx_busy) state_next = ISSUE;
            ISSUE:     state_next = WAIT_BUSY;
            WAIT_BUSY: if (bus.tx_busy) state_next = WAIT_DONE;
            WAIT_DONE: if (!bus.tx_busy) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tx_data  <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
            if (state == IDLE && state_next == ISSUE) tx_data <= mem[rd_ptr];
            if (drop)             overflow <= 1'b1;
            else if (bus.clr_ovf) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.wr_data;
    end
endmodule
